// File: rtl/memory_stage_if.sv
// Data-memory port of the memory stage: one outstanding request at a time,
// completed by a single-cycle acknowledge from the memory side.
interface memory_stage_if;
  logic        oMemReq;
  logic        oMemWe;
  logic [15:0] oMemAddr;
  logic [15:0] oMemWData;
  logic [15:0] iMemRData;
  logic        iMemAck;

  modport master (
    output oMemReq,
    output oMemWe,
    output oMemAddr,
    output oMemWData,
    input  iMemRData,
    input  iMemAck
  );

  modport slave (
    input  oMemReq,
    input  oMemWe,
    input  oMemAddr,
    input  oMemWData,
    output iMemRData,
    output iMemAck
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage of the pipeline. Non-memory instructions pass to writeback
// after one cycle. Loads and stores raise a registered request, stall the
// upstream stages until the memory acknowledges or a 16-cycle wait budget
// runs out, then retire into writeback. A timeout is recorded in a sticky
// error flag and a timed-out load returns zero.
module memory_stage (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [15:0]    iAluOut,
  input  logic [15:0]    iData2,
  input  logic [15:0]    iBusData,
  input  logic           iAlutoReg,
  input  logic           iMemtoReg,
  input  logic           iBustoReg,
  input  logic [3:0]     iDest,
  input  logic           iMemRead,
  input  logic           iMemWrite,
  memory_stage_if.master mem,
  output logic           oStall,
  output logic [15:0]    oWbData,
  output logic [3:0]     oWbDest,
  output logic           oWbEn,
  output logic           oMemErr
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Last WAIT cycle index: request is high for WAIT_LAST+1 cycles at most.
  localparam logic [3:0] WAIT_LAST = 4'hF;

  state_t      state;
  state_t      stateNext;
  logic [3:0]  waitCnt;
  logic [3:0]  waitCntNext;

  logic        memReqNext;
  logic        memWeNext;
  logic [15:0] memAddrNext;
  logic [15:0] memWDataNext;
  logic [15:0] wbDataNext;
  logic [3:0]  wbDestNext;
  logic        wbEnNext;
  logic        memErrNext;

  logic        memOp;
  logic        wbAny;

  assign memOp = iMemRead | iMemWrite;
  assign wbAny = iAlutoReg | iMemtoReg | iBustoReg;

  // Writeback source for a retiring memory instruction.
  function automatic logic [15:0] memWbData(input logic        memToReg,
                                            input logic [15:0] rdata,
                                            input logic [15:0] aluData);
    return memToReg ? rdata : aluData;
  endfunction

  // Writeback source when the access timed out: loads return zero.
  function automatic logic [15:0] timeoutWbData(input logic        wasWrite,
                                                input logic        memToReg,
                                                input logic [15:0] aluData);
    return (!wasWrite || memToReg) ? 16'h0000 : aluData;
  endfunction

  // Writeback source for a non-memory instruction.
  function automatic logic [15:0] passWbData(input logic        busToReg,
                                             input logic [15:0] busData,
                                             input logic [15:0] aluData);
    return busToReg ? busData : aluData;
  endfunction

  // Next-state, stall and next register values; every target holds by default.
  always_comb begin
    stateNext    = state;
    waitCntNext  = waitCnt;
    memReqNext   = mem.oMemReq;
    memWeNext    = mem.oMemWe;
    memAddrNext  = mem.oMemAddr;
    memWDataNext = mem.oMemWData;
    wbDataNext   = oWbData;
    wbDestNext   = oWbDest;
    wbEnNext     = oWbEn;
    memErrNext   = oMemErr;
    oStall       = 1'b0;

    case (state)
      IDLE: begin
        if (memOp) begin
          // Launch the access; a read wins when both flags are set.
          oStall       = 1'b1;
          stateNext    = WAIT;
          waitCntNext  = 4'd0;
          memReqNext   = 1'b1;
          memWeNext    = iMemWrite & ~iMemRead;
          memAddrNext  = iAluOut;
          memWDataNext = iData2;
          wbEnNext     = 1'b0;
        end else begin
          wbEnNext   = wbAny;
          wbDestNext = iDest;
          wbDataNext = passWbData(iBustoReg, iBusData, iAluOut);
        end
      end

      WAIT: begin
        if (mem.iMemAck) begin
          // Completion: release upstream this cycle, retire at the edge.
          stateNext  = IDLE;
          memReqNext = 1'b0;
          wbEnNext   = wbAny;
          wbDestNext = iDest;
          wbDataNext = memWbData(iMemtoReg, mem.iMemRData, iAluOut);
        end else if (waitCnt == WAIT_LAST) begin
          // Budget exhausted: abandon the access and flag the error.
          stateNext  = IDLE;
          memReqNext = 1'b0;
          memErrNext = 1'b1;
          wbEnNext   = wbAny;
          wbDestNext = iDest;
          wbDataNext = timeoutWbData(mem.oMemWe, iMemtoReg, iAluOut);
        end else begin
          oStall      = 1'b1;
          waitCntNext = waitCnt + 4'd1;
          wbEnNext    = 1'b0;
        end
      end

      default: begin
        stateNext  = IDLE;
        memReqNext = 1'b0;
      end
    endcase
  end

  // State, counter and all registered outputs; reset aborts any access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      waitCnt       <= 4'd0;
      mem.oMemReq   <= 1'b0;
      mem.oMemWe    <= 1'b0;
      mem.oMemAddr  <= 16'h0000;
      mem.oMemWData <= 16'h0000;
      oWbData       <= 16'h0000;
      oWbDest       <= 4'd0;
      oWbEn         <= 1'b0;
      oMemErr       <= 1'b0;
    end else begin
      state         <= stateNext;
      waitCnt       <= waitCntNext;
      mem.oMemReq   <= memReqNext;
      mem.oMemWe    <= memWeNext;
      mem.oMemAddr  <= memAddrNext;
      mem.oMemWData <= memWDataNext;
      oWbData       <= wbDataNext;
      oWbDest       <= wbDestNext;
      oWbEn         <= wbEnNext;
      oMemErr       <= memErrNext;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: each instruction is expanded into an expected
// per-cycle timeline from its latency (ack offset or timeout), and a single
// compare process checks the DUT against that timeline every cycle, plus a
// list of hand-computed literal pins.
module tb_memory_stage;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] iAluOut, iData2, iBusData;
  logic        iAlutoReg, iMemtoReg, iBustoReg;
  logic [3:0]  iDest;
  logic        iMemRead, iMemWrite;
  logic        oStall;
  logic [15:0] oWbData;
  logic [3:0]  oWbDest;
  logic        oWbEn, oMemErr;

  memory_stage_if mem();

  memory_stage dut (
    .clk(clk), .rst_n(rst_n),
    .iAluOut(iAluOut), .iData2(iData2), .iBusData(iBusData),
    .iAlutoReg(iAlutoReg), .iMemtoReg(iMemtoReg), .iBustoReg(iBustoReg),
    .iDest(iDest), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
    .mem(mem),
    .oStall(oStall), .oWbData(oWbData), .oWbDest(oWbDest),
    .oWbEn(oWbEn), .oMemErr(oMemErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] alu, d2, bus, rdata;
    logic        aluR, memR, busR, rd, wr, strayAck;
    logic [3:0]  dest;
    int          ackOff;   // WAIT cycle index of ack, -1 = never (timeout)
    int          abortAt;  // WAIT cycle index with rst_n=0, -1 = none
  } ins_t;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
    string       name;
  } pin_t;

  // Expected timeline
  bit          fV[MAXC];
  logic        fStall[MAXC], fReq[MAXC], fErr[MAXC];
  bit          mV[MAXC];
  logic        mWe[MAXC];
  logic [15:0] mAddr[MAXC], mWData[MAXC];
  bit          wV[MAXC], wDV[MAXC];
  logic        wEn[MAXC];
  logic [15:0] wData[MAXC];
  logic [3:0]  wDest[MAXC];
  pin_t        pins[$];

  int   cyc;
  logic errS;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] probe(input int kind);
    case (kind)
      0: return oWbData;
      1: return 16'(oWbEn);
      2: return 16'(mem.oMemWe);
      3: return 16'(oMemErr);
      4: return 16'(mem.oMemReq);
      5: return 16'(oStall);
      6: return 16'(oWbDest);
      7: return mem.oMemWData;
      default: return mem.oMemAddr;
    endcase
  endfunction

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (cyc > 0 && cyc < MAXC) begin
      if (fV[cyc]) begin
        chk("stall", 16'(oStall), 16'(fStall[cyc]));
        chk("memReq", 16'(mem.oMemReq), 16'(fReq[cyc]));
        chk("memErr", 16'(oMemErr), 16'(fErr[cyc]));
      end
      if (mV[cyc]) begin
        chk("memWe", 16'(mem.oMemWe), 16'(mWe[cyc]));
        chk("memAddr", mem.oMemAddr, mAddr[cyc]);
        chk("memWData", mem.oMemWData, mWData[cyc]);
      end
      if (wV[cyc]) begin
        chk("wbEn", 16'(oWbEn), 16'(wEn[cyc]));
        if (wDV[cyc]) begin
          chk("wbData", oWbData, wData[cyc]);
          chk("wbDest", 16'(oWbDest), 16'(wDest[cyc]));
        end
      end
      foreach (pins[i]) begin
        if (pins[i].cyc == cyc) chk(pins[i].name, probe(pins[i].kind), pins[i].val);
      end
    end
  end

  task automatic addPin(input int c, input int kind, input logic [15:0] val, input string name);
    pin_t p;
    p.cyc = c; p.kind = kind; p.val = val; p.name = name;
    pins.push_back(p);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic ins_t blank();
    ins_t t;
    t.alu = 16'h0; t.d2 = 16'h0; t.bus = 16'h0; t.rdata = 16'h0;
    t.aluR = 1'b0; t.memR = 1'b0; t.busR = 1'b0; t.rd = 1'b0; t.wr = 1'b0;
    t.strayAck = 1'b0; t.dest = 4'd0; t.ackOff = 0; t.abortAt = -1;
    return t;
  endfunction

  // Everything after a reset edge is zero; later plans are discarded.
  task automatic resetExpect(input int t);
    errS = 1'b0;
    for (int k = t; k < MAXC; k++) begin
      fV[k] = 1'b0; mV[k] = 1'b0; wV[k] = 1'b0; wDV[k] = 1'b0;
    end
    fV[t] = 1'b1; fStall[t] = 1'b0; fReq[t] = 1'b0; fErr[t] = 1'b0;
    mV[t] = 1'b1; mWe[t] = 1'b0; mAddr[t] = 16'h0; mWData[t] = 16'h0;
    wV[t] = 1'b1; wEn[t] = 1'b0; wDV[t] = 1'b1; wData[t] = 16'h0; wDest[t] = 4'd0;
  endtask

  // Present one instruction at the current cycle, plan its timeline, and
  // play the memory side (ack at the chosen WAIT cycle).
  task automatic exec(input ins_t t);
    int          c, a;
    logic        en;
    logic [15:0] res;
    c = cyc;
    rst_n = 1'b1;
    iAluOut = t.alu; iData2 = t.d2; iBusData = t.bus;
    iAlutoReg = t.aluR; iMemtoReg = t.memR; iBustoReg = t.busR;
    iDest = t.dest; iMemRead = t.rd; iMemWrite = t.wr;
    mem.iMemAck = t.strayAck;
    mem.iMemRData = 16'($urandom);
    en = t.aluR | t.memR | t.busR;
    if (!(t.rd || t.wr)) begin
      fV[c] = 1'b1; fStall[c] = 1'b0; fReq[c] = 1'b0; fErr[c] = errS;
      wV[c+1] = 1'b1; wEn[c+1] = en; wDV[c+1] = en;
      wData[c+1] = t.busR ? t.bus : t.alu; wDest[c+1] = t.dest;
      nextCycle();
    end else begin
      a = (t.ackOff < 0) ? 15 : t.ackOff;
      for (int j = 0; j <= a + 1; j++) begin
        fV[c+j] = 1'b1; fStall[c+j] = (j <= a); fReq[c+j] = (j > 0); fErr[c+j] = errS;
      end
      for (int j = 1; j <= a + 1; j++) begin
        mV[c+j] = 1'b1; mWe[c+j] = t.wr && !t.rd; mAddr[c+j] = t.alu; mWData[c+j] = t.d2;
        wV[c+j] = 1'b1; wEn[c+j] = 1'b0; wDV[c+j] = 1'b0;
      end
      if (t.ackOff >= 0) res = t.memR ? t.rdata : t.alu;
      else               res = t.rd ? 16'h0000 : t.alu;
      wV[c+a+2] = 1'b1; wEn[c+a+2] = en; wDV[c+a+2] = en;
      wData[c+a+2] = res; wDest[c+a+2] = t.dest;
      if (t.ackOff < 0) errS = 1'b1;
      nextCycle();
      for (int j = 0; j <= a; j++) begin
        if (t.abortAt == j) begin
          rst_n = 1'b0;
          mem.iMemAck = 1'b0;
          nextCycle();
          resetExpect(cyc);
          return;
        end
        mem.iMemAck = (t.ackOff == j);
        mem.iMemRData = (t.ackOff == j) ? t.rdata : 16'($urandom);
        nextCycle();
      end
    end
  endtask

  initial begin
    ins_t t;
    int   c, k;
    cyc = 0; errS = 1'b0; rst_n = 1'b0;
    iAluOut = 16'h0; iData2 = 16'h0; iBusData = 16'h0;
    iAlutoReg = 1'b0; iMemtoReg = 1'b0; iBustoReg = 1'b0;
    iDest = 4'd0; iMemRead = 1'b0; iMemWrite = 1'b0;
    mem.iMemAck = 1'b0; mem.iMemRData = 16'h0;
    nextCycle();
    resetExpect(cyc);
    nextCycle();
    resetExpect(cyc);

    // ALU op
    t = blank(); t.alu = 16'h1234; t.aluR = 1'b1; t.dest = 4'd3;
    c = cyc;
    addPin(c, 5, 16'h0, "alu_stall");
    addPin(c+1, 0, 16'h1234, "alu_wbData");
    addPin(c+1, 6, 16'h3, "alu_wbDest");
    addPin(c+1, 1, 16'h1, "alu_wbEn");
    exec(t);

    // Load, ack 3 cycles after request rises
    t = blank(); t.alu = 16'h0040; t.rd = 1'b1; t.memR = 1'b1; t.dest = 4'd5;
    t.ackOff = 3; t.rdata = 16'hBEEF; t.strayAck = 1'b1;
    c = cyc;
    for (int i = 0; i < 4; i++) addPin(c+i, 5, 16'h1, "load_stallHigh");
    addPin(c+4, 5, 16'h0, "load_stallLow");
    addPin(c+1, 8, 16'h0040, "load_memAddr");
    addPin(c+1, 2, 16'h0, "load_memWe");
    addPin(c+5, 0, 16'hBEEF, "load_wbData");
    addPin(c+5, 1, 16'h1, "load_wbEn");
    exec(t);

    // Store, ack 1 cycle after request rises
    t = blank(); t.alu = 16'h0100; t.wr = 1'b1; t.d2 = 16'h00A5; t.ackOff = 1;
    c = cyc;
    addPin(c+1, 2, 16'h1, "store_memWe");
    addPin(c+1, 7, 16'h00A5, "store_memWData");
    addPin(c+2, 4, 16'h1, "store_reqAtAck");
    addPin(c+3, 4, 16'h0, "store_reqDropped");
    addPin(c+3, 1, 16'h0, "store_wbEn");
    exec(t);

    // Read and write both set: treated as read
    t = blank(); t.alu = 16'h0222; t.rd = 1'b1; t.wr = 1'b1; t.memR = 1'b1;
    t.d2 = 16'hFFFF; t.rdata = 16'h5A5A; t.ackOff = 0; t.dest = 4'd9;
    c = cyc;
    addPin(c+1, 2, 16'h0, "rdwr_memWe");
    addPin(c+2, 0, 16'h5A5A, "rdwr_wbData");
    exec(t);

    // Back-to-back loads
    t = blank(); t.alu = 16'h0300; t.rd = 1'b1; t.memR = 1'b1; t.dest = 4'd1;
    t.ackOff = 2; t.rdata = 16'h1111;
    c = cyc;
    addPin(c+4, 0, 16'h1111, "b2b_firstData");
    addPin(c+4, 4, 16'h0, "b2b_reqGap");
    addPin(c+4, 5, 16'h1, "b2b_stallNoGap");
    addPin(c+5, 4, 16'h1, "b2b_secondReq");
    addPin(c+6, 0, 16'h2222, "b2b_secondData");
    exec(t);
    t.alu = 16'h0302; t.dest = 4'd2; t.ackOff = 0; t.rdata = 16'h2222;
    exec(t);

    // Reset pulse in WAIT, then a late ack
    t = blank(); t.alu = 16'h0400; t.rd = 1'b1; t.memR = 1'b1; t.dest = 4'd4;
    t.ackOff = 10; t.abortAt = 2; t.rdata = 16'h7777;
    c = cyc;
    addPin(c+3, 4, 16'h1, "abort_reqBefore");
    addPin(c+4, 4, 16'h0, "abort_reqAfter");
    addPin(c+5, 1, 16'h0, "abort_lateAckNoWb");
    exec(t);
    t = blank(); t.strayAck = 1'b1;
    exec(t);
    exec(t);

    // Timeout: load with no ack
    t = blank(); t.alu = 16'h0ABC; t.rd = 1'b1; t.memR = 1'b1; t.dest = 4'd7; t.ackOff = -1;
    c = cyc;
    addPin(c+1, 4, 16'h1, "to_reqFirst");
    addPin(c+16, 4, 16'h1, "to_reqLast");
    addPin(c+17, 4, 16'h0, "to_reqDropped");
    addPin(c+15, 5, 16'h1, "to_stallHigh");
    addPin(c+16, 5, 16'h0, "to_stallRelease");
    addPin(c+16, 3, 16'h0, "to_errBefore");
    addPin(c+17, 3, 16'h1, "to_errSet");
    addPin(c+17, 0, 16'h0000, "to_wbData");
    addPin(c+17, 1, 16'h1, "to_wbEn");
    exec(t);

    // Randomized instruction mix
    for (int n = 0; n < 80; n++) begin
      t = blank();
      t.alu = 16'($urandom); t.d2 = 16'($urandom); t.bus = 16'($urandom);
      t.rdata = 16'($urandom); t.dest = 4'($urandom); t.strayAck = 1'($urandom);
      k = int'($urandom_range(3, 0));
      if (k < 2) begin
        t.aluR = 1'($urandom); t.busR = 1'($urandom); t.memR = 1'($urandom);
      end else begin
        if (k == 2) begin
          t.rd = 1'b1; t.memR = 1'b1; t.wr = ($urandom_range(3, 0) == 0);
        end else begin
          t.wr = 1'b1; t.aluR = ($urandom_range(3, 0) == 0);
        end
        t.ackOff = ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(15, 0));
      end
      exec(t);
    end

    // Error stays set with no reset since the timeout
    addPin(cyc, 3, 16'h1, "err_sticky");
    t = blank();
    exec(t);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
